// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file widths and shared types for the write-back path.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the pointer remembers the last winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    // Walk from farthest to nearest so the slot right after the pointer wins last.
    always_comb begin
        o_grant = '0;
        w_win   = r_ptr;
        for (int i = N; i >= 1; i--) begin
            int k;
            k = (int'(r_ptr) + i) % N;
            if (i_req[k[PW-1:0]]) begin
                o_grant              = '0;
                o_grant[k[PW-1:0]]   = 1'b1;
                w_win                = k[PW-1:0];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ptr <= PW'(N - 1);
        else if (i_advance && |i_req)
            r_ptr <= w_win;
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: shares the regfile write port among requesters and tracks
// in-flight destinations for RAW/WAW hazard reporting.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_REQ-1:0]            i_req_valid,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic [N_REQ*REG_ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*XLEN-1:0]       i_req_data,
    output logic [REG_ADDR_W-1:0]       o_rd_addr,
    output logic [XLEN-1:0]             o_rd_data,
    output logic                        o_rd_wren,
    input  logic                        i_issue_valid,
    input  logic [REG_ADDR_W-1:0]       i_issue_rd,
    output logic                        o_issue_stall,
    input  logic [REG_ADDR_W-1:0]       i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]       i_rs2_addr,
    output logic                        o_rs1_busy,
    output logic                        o_rs2_busy,
    output logic [NUM_REGS-1:0]         o_busy_map
);
    logic [N_REQ-1:0]    w_grant;
    logic                w_hs;
    reg_addr_t           w_addr;
    xlen_t               w_data;
    reg_addr_t           r_addr;
    xlen_t               r_data;
    logic                r_wren;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_set;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req_valid),
        .i_advance (w_hs),
        .o_grant   (w_grant)
    );

    assign w_hs        = |w_grant;
    assign o_req_ready = w_grant;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int k = 0; k < N_REQ; k++)
            if (w_grant[k]) begin
                w_addr = i_req_addr[k*REG_ADDR_W +: REG_ADDR_W];
                w_data = i_req_data[k*XLEN +: XLEN];
            end
    end

    assign o_issue_stall = i_issue_valid && (i_issue_rd != '0) && r_busy[i_issue_rd];
    assign w_set         = i_issue_valid && !o_issue_stall && (i_issue_rd != '0);

    // Set is applied after clear so a same-cycle collision leaves the bit busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wren) w_busy_nxt[r_addr] = 1'b0;
        if (w_set) w_busy_nxt[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wren <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_busy <= '0;
        end else begin
            r_wren <= w_hs && (w_addr != '0);
            r_busy <= w_busy_nxt;
            if (w_hs) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
        end
    end

    assign o_rd_wren  = r_wren;
    assign o_rd_addr  = r_addr;
    assign o_rd_data  = r_data;
    assign o_busy_map = r_busy;
    assign o_rs1_busy = r_busy[i_rs1_addr] && (i_rs1_addr != '0);
    assign o_rs2_busy = r_busy[i_rs2_addr] && (i_rs2_addr != '0);
endmodule
